vx_cta_dispatch: RTL and testbench
==================================

Name: vx_cta_dispatch

Overview:
- Receiving end of the KMU raster-bus CTA stream; sits per core, downstream of the KMU.
- Buffers incoming CTA descriptors and gang-allocates free hardware warp slots for a whole CTA at once.
- Emits one warp-spawn request per warp to the core's warp scheduler.
- Frees slots on warp-completion reports.

Parameters:
- NUM_WARPS, 4 — hardware warp slots; power of two, ≥2.
- NUM_THREADS, 4 — threads per warp; width of spawn_tmask.
- QUEUE_DEPTH, 2 — CTA descriptor buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- req_valid  in  1  CTA descriptor valid
- req_ready  out  1  descriptor buffer not full
- req_num_warps  in  32  warps in CTA
- req_start_pc  in  32  kernel PC
- req_param  in  32  kernel argument pointer
- req_cta_x / req_cta_y / req_cta_z  in  32 each  CTA coordinates
- req_cta_id  in  32  linear CTA id
- spawn_valid  out  1  warp spawn request
- spawn_ready  in  1  scheduler accepts spawn
- spawn_wid  out  log2(NUM_WARPS)  allocated slot
- spawn_tmask  out  NUM_THREADS  thread mask, all ones
- spawn_pc / spawn_param  out  32 each  from descriptor
- spawn_cta_x / spawn_cta_y / spawn_cta_z / spawn_cta_id  out  32 each  from descriptor
- spawn_lwid  out  32  warp index within CTA, 0..num_warps-1
- done_valid  in  1  warp completed
- done_wid  in  log2(NUM_WARPS)  completed slot
- busy  out  1  queue non-empty, or FSM not IDLE, or any slot allocated
- cta_err  out  1  sticky; set when a CTA is oversize

Behaviour:
- Reset (reset==0 at posedge): queue empty, all slots free, FSM=IDLE, spawn_valid=0, cta_err=0, busy=0.
  - req_ready=0 during reset, 1 in the first cycle after.
- Queue: push on req_valid&&req_ready. req_ready = !full; no combinational path from req_valid. Push and pop in the same cycle are allowed when full.
- Free bitmap: NUM_WARPS bits.
  - done_valid sets bit done_wid at the next edge.
  - done on an already-free slot is ignored.
- FSM:
  - IDLE: if queue non-empty, latch head descriptor, pop, go to CHECK.
  - CHECK:
    - num_warps==0: drop the CTA, go to IDLE, no spawn.
    - num_warps>NUM_WARPS: set cta_err, drop, go to IDLE.
    - popcount(free) ≥ num_warps (registered bitmap): go to SPAWN, lwid=0.
    - Otherwise stay in CHECK.
  - SPAWN:
    - spawn_valid=1; spawn_wid = lowest free slot.
    - On spawn_ready: clear that bit and increment lwid.
    - When lwid==num_warps-1 is accepted: go to IDLE.
- Handshake rules:
  - spawn outputs are registered.
  - spawn payload and spawn_valid hold stable until accepted.
  - Completions only add free bits, so the lowest-free choice stays valid within a CTA.
- Simultaneous done and spawn on different slots: both apply. Same slot cannot occur (spawn targets a free slot).
- Latency:
  - First spawn_valid no earlier than 3 cycles after the push (push → IDLE pop → CHECK → SPAWN).
  - One warp per cycle under continuous spawn_ready.
- Widths: 32-bit fields pass through unmodified. Only log2(NUM_WARPS)+1 bits of num_warps are compared after the oversize check.
- Reset mid-operation: the in-flight CTA and queued CTAs are discarded; all slots freed.

Optional Feature:
- Macro: VX_CTA_DISPATCH_PERF_EN.
- Defined: adds 32-bit outputs perf_ctas, perf_warps and perf_stall.
  - perf_ctas increments per CTA finishing SPAWN.
  - perf_warps increments per accepted spawn.
  - perf_stall increments per cycle in CHECK lacking slots.
  - All wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent.

Decomposition:
- VX_gpu_pkg gets:
  - cta_desc_t (num_warps, start_pc, param, cta_x/y/z, cta_id).
  - CTA_QUEUE_DEPTH default.
  - cta_dispatch_state_t enum {IDLE, CHECK, SPAWN}.
- Sub-module: the descriptor queue is the existing VX_fifo_queue, instantiated with cta_desc_t width.
- Slot allocation (priority encoder plus popcount) is inline.

Test Plan:
- One CTA, num_warps=3, spawn_ready=1 → spawn_wid 0,1,2 on consecutive cycles, lwid 0,1,2, busy stays 1 until three done_valid arrive.
- Two CTAs of 3 warps, NUM_WARPS=4 → second CTA waits in CHECK; after done_wid=1, 2 and 0 it spawns wids 0,1,2.
- num_warps=0, then num_warps=2 → no spawn for the first; second spawns wids 0,1; cta_err=0.
- num_warps=5 with NUM_WARPS=4 → cta_err=1 sticky, no spawn, next CTA proceeds normally.
- spawn_ready held low 4 cycles → spawn_valid/wid/pc stable; QUEUE_DEPTH+1 pushes → req_ready=0 when full.
- Reset low mid-SPAWN (1 of 3 warps sent) → next cycle spawn_valid=0, busy=0, all slots free, req_ready=1.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// rtl/VX_gpu_pkg.sv - shared GPU types: CTA descriptor, dispatcher state, queue depth default
package VX_gpu_pkg;

  localparam int CTA_QUEUE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] num_warps;
    logic [31:0] start_pc;
    logic [31:0] param;
    logic [31:0] cta_x;
    logic [31:0] cta_y;
    logic [31:0] cta_z;
    logic [31:0] cta_id;
  } cta_desc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SPAWN = 2'd2
  } cta_dispatch_state_t;

endpackage

// File: rtl/VX_fifo_queue.sv
// rtl/VX_fifo_queue.sv - synchronous FIFO; accepts a push while full if a pop frees the slot
module VX_fifo_queue #(
  parameter int DATAW = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vx_cta_dispatch.sv
// rtl/vx_cta_dispatch.sv - per-core CTA dispatcher: buffers descriptors, gang-allocates warp slots, spawns warps
// Optional perf counters (perf_ctas/perf_warps/perf_stall) enabled by VX_CTA_DISPATCH_PERF_EN
module vx_cta_dispatch
  import VX_gpu_pkg::*;
#(
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int QUEUE_DEPTH = CTA_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [31:0]                  req_num_warps,
  input  logic [31:0]                  req_start_pc,
  input  logic [31:0]                  req_param,
  input  logic [31:0]                  req_cta_x,
  input  logic [31:0]                  req_cta_y,
  input  logic [31:0]                  req_cta_z,
  input  logic [31:0]                  req_cta_id,
  output logic                         spawn_valid,
  input  logic                         spawn_ready,
  output logic [$clog2(NUM_WARPS)-1:0] spawn_wid,
  output logic [NUM_THREADS-1:0]       spawn_tmask,
  output logic [31:0]                  spawn_pc,
  output logic [31:0]                  spawn_param,
  output logic [31:0]                  spawn_cta_x,
  output logic [31:0]                  spawn_cta_y,
  output logic [31:0]                  spawn_cta_z,
  output logic [31:0]                  spawn_cta_id,
  output logic [31:0]                  spawn_lwid,
  input  logic                         done_valid,
  input  logic [$clog2(NUM_WARPS)-1:0] done_wid,
`ifdef VX_CTA_DISPATCH_PERF_EN
  output logic [31:0]                  perf_ctas,
  output logic [31:0]                  perf_warps,
  output logic [31:0]                  perf_stall,
`endif
  output logic                         busy,
  output logic                         cta_err
);

  localparam int LW = $clog2(NUM_WARPS);

  cta_desc_t           q_din;
  cta_desc_t           q_dout;
  cta_desc_t           desc_r;
  logic                q_empty;
  logic                q_full;
  logic                q_pop;
  logic                rdy_r;
  cta_dispatch_state_t state;

  logic [NUM_WARPS-1:0] free_r;
  logic [NUM_WARPS-1:0] free_n;
  logic [NUM_WARPS-1:0] free_after;
  logic [NUM_WARPS-1:0] done_mask;
  logic [NUM_WARPS-1:0] spawn_mask;
  logic [LW:0]          free_cnt;
  logic [LW-1:0]        lowest;
  logic [LW-1:0]        lowest_after;
  logic [LW:0]          nw;
  logic                 nw_zero;
  logic                 nw_big;
  logic                 fire;
  logic                 last_fire;

  assign q_din = '{num_warps: req_num_warps, start_pc: req_start_pc, param: req_param,
                   cta_x: req_cta_x, cta_y: req_cta_y, cta_z: req_cta_z, cta_id: req_cta_id};

  // ready is held low through reset and comes up the first cycle after it
  assign req_ready = rdy_r && !q_full;
  assign q_pop     = (state == IDLE) && !q_empty;

  VX_fifo_queue #(
    .DATAW ($bits(cta_desc_t)),
    .DEPTH (QUEUE_DEPTH)
  ) desc_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (req_valid && req_ready),
    .pop      (q_pop),
    .data_in  (q_din),
    .data_out (q_dout),
    .empty    (q_empty),
    .full     (q_full)
  );

  assign nw        = desc_r.num_warps[LW:0];
  assign nw_zero   = (desc_r.num_warps == '0);
  assign nw_big    = (desc_r.num_warps > 32'(NUM_WARPS));
  assign fire      = spawn_valid && spawn_ready;
  assign last_fire = fire && (spawn_lwid[LW:0] == nw - 1'b1);

  always_comb begin
    done_mask  = '0;
    spawn_mask = '0;
    if (done_valid) done_mask[done_wid] = 1'b1;
    if (fire)       spawn_mask[spawn_wid] = 1'b1;
    free_after = free_r & ~spawn_mask;
    free_n     = (free_r | done_mask) & ~spawn_mask;
    free_cnt   = '0;
    for (int i = 0; i < NUM_WARPS; i++) free_cnt = free_cnt + (LW+1)'(free_r[i]);
    lowest       = '0;
    lowest_after = '0;
    for (int i = NUM_WARPS-1; i >= 0; i--) begin
      if (free_r[i])     lowest       = LW'(i);
      if (free_after[i]) lowest_after = LW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      rdy_r       <= 1'b0;
      free_r      <= '1;
      desc_r      <= '0;
      spawn_valid <= 1'b0;
      spawn_wid   <= '0;
      spawn_lwid  <= '0;
      cta_err     <= 1'b0;
    end else begin
      rdy_r  <= 1'b1;
      free_r <= free_n;
      case (state)
        IDLE: begin
          if (!q_empty) begin
            desc_r <= q_dout;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (nw_zero) begin
            state <= IDLE;
          end else if (nw_big) begin
            cta_err <= 1'b1;
            state   <= IDLE;
          end else if (free_cnt >= nw) begin
            state       <= SPAWN;
            spawn_valid <= 1'b1;
            spawn_wid   <= lowest;
            spawn_lwid  <= '0;
          end
        end
        SPAWN: begin
          if (last_fire) begin
            spawn_valid <= 1'b0;
            state       <= IDLE;
          end else if (fire) begin
            spawn_lwid <= spawn_lwid + 1'b1;
            spawn_wid  <= lowest_after;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign spawn_tmask  = '1;
  assign spawn_pc     = desc_r.start_pc;
  assign spawn_param  = desc_r.param;
  assign spawn_cta_x  = desc_r.cta_x;
  assign spawn_cta_y  = desc_r.cta_y;
  assign spawn_cta_z  = desc_r.cta_z;
  assign spawn_cta_id = desc_r.cta_id;
  assign busy         = !q_empty || (state != IDLE) || (free_r != {NUM_WARPS{1'b1}});

`ifdef VX_CTA_DISPATCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_ctas  <= '0;
      perf_warps <= '0;
      perf_stall <= '0;
    end else begin
      if (fire)      perf_warps <= perf_warps + 1'b1;
      if (last_fire) perf_ctas  <= perf_ctas + 1'b1;
      if (state == CHECK && !nw_zero && !nw_big && free_cnt < nw) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_cta_dispatch.sv
// tb/tb_vx_cta_dispatch.sv - self-checking bench for vx_cta_dispatch
module tb_vx_cta_dispatch;

  localparam int NW = 4;
  localparam int NT = 4;
  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_num_warps = '0, req_start_pc = '0, req_param = '0;
  logic [31:0] req_cta_x = '0, req_cta_y = '0, req_cta_z = '0, req_cta_id = '0;
  logic        spawn_valid;
  logic        spawn_ready = 1'b0;
  logic [1:0]  spawn_wid;
  logic [NT-1:0] spawn_tmask;
  logic [31:0] spawn_pc, spawn_param, spawn_cta_x, spawn_cta_y, spawn_cta_z, spawn_cta_id, spawn_lwid;
  logic        done_valid = 1'b0;
  logic [1:0]  done_wid = '0;
  logic        busy;
  logic        cta_err;
`ifdef VX_CTA_DISPATCH_PERF_EN
  logic [31:0] perf_ctas, perf_warps, perf_stall;
`endif

  always #5 clk = ~clk;

  vx_cta_dispatch #(.NUM_WARPS(NW), .NUM_THREADS(NT), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_num_warps(req_num_warps),
    .req_start_pc(req_start_pc), .req_param(req_param), .req_cta_x(req_cta_x),
    .req_cta_y(req_cta_y), .req_cta_z(req_cta_z), .req_cta_id(req_cta_id),
    .spawn_valid(spawn_valid), .spawn_ready(spawn_ready), .spawn_wid(spawn_wid),
    .spawn_tmask(spawn_tmask), .spawn_pc(spawn_pc), .spawn_param(spawn_param),
    .spawn_cta_x(spawn_cta_x), .spawn_cta_y(spawn_cta_y), .spawn_cta_z(spawn_cta_z),
    .spawn_cta_id(spawn_cta_id), .spawn_lwid(spawn_lwid),
    .done_valid(done_valid), .done_wid(done_wid),
`ifdef VX_CTA_DISPATCH_PERF_EN
    .perf_ctas(perf_ctas), .perf_warps(perf_warps), .perf_stall(perf_stall),
`endif
    .busy(busy), .cta_err(cta_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [31:0] nw, input logic [31:0] tag);
    req_num_warps = nw;
    req_start_pc  = 32'h8000_0000 | tag;
    req_param     = 32'h4000_0000 | tag;
    req_cta_x     = tag + 1;
    req_cta_y     = tag + 2;
    req_cta_z     = tag + 3;
    req_cta_id    = tag;
  endtask

  task automatic push(input logic [31:0] nw, input logic [31:0] tag);
    bit ok;
    ok = 0;
    drive_req(nw, tag);
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (req_ready) ok = 1;
      step();
    end
    req_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = 1'b0; spawn_ready = 1'b0; done_valid = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  // spawn_ready held high; wids packed 4 bits per spawn in order
  task automatic collect(input int cycles, output int cnt, output logic [31:0] seq);
    spawn_ready = 1'b1;
    cnt = 0;
    seq = '0;
    repeat (cycles) begin
      if (spawn_valid) begin
        if (cnt < 8) seq[4*cnt +: 4] = 4'(spawn_wid);
        cnt++;
      end
      step();
    end
    spawn_ready = 1'b0;
  endtask

  task automatic complete(input int wid);
    done_valid = 1'b1;
    done_wid   = 2'(wid);
    step();
    done_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] num_warps;
    int          exp_cnt;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] n;
    logic [31:0] tag;
  } cta_t;

  vec_t        vecs[8];
  cta_t        exp_q[$];
  int          nsp, first, cnt, cur, r, k, idx, fw;
  logic [31:0] seq, nwv, tagc, ppc, plw;
  logic [1:0]  pw;
  logic [NW-1:0] alloc, wmask;
  bit          exp_err, pend, fired, feeding, found;

  initial begin
    vecs[0] = '{32'd1, 1, 1'b0};
    vecs[1] = '{32'd2, 2, 1'b0};
    vecs[2] = '{32'd3, 3, 1'b0};
    vecs[3] = '{32'd4, 4, 1'b0};
    vecs[4] = '{32'd0, 0, 1'b0};
    vecs[5] = '{32'd5, 0, 1'b1};
    vecs[6] = '{32'hFFFF_FFFF, 0, 1'b1};
    vecs[7] = '{32'h1000_0002, 0, 1'b1};

    // reset state
    reset = 1'b0;
    step(); step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_spawn_valid", spawn_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cta_err", cta_err, 0);
    reset = 1'b1;
    step();
    chk("post_rst_req_ready", req_ready, 1);

    // table: single CTA from a clean reset
    for (int v = 0; v < 8; v++) begin
      do_reset();
      drive_req(vecs[v].num_warps, 32'(v));
      req_valid = 1'b1;
      spawn_ready = 1'b1;
      nsp = 0;
      first = -1;
      for (int c = 1; c <= 16; c++) begin
        step();
        req_valid = 1'b0;
        if (spawn_valid) begin
          if (first < 0) first = c;
          chk("tbl_wid", spawn_wid, nsp);
          chk("tbl_lwid", spawn_lwid, nsp);
          chk("tbl_pc", spawn_pc, 32'h8000_0000 | v);
          chk("tbl_param", spawn_param, 32'h4000_0000 | v);
          chk("tbl_xyz", {spawn_cta_x[15:0], spawn_cta_y[15:0], spawn_cta_z[15:0]}, {16'(v+1), 16'(v+2), 16'(v+3)});
          chk("tbl_id", spawn_cta_id, v);
          chk("tbl_tmask", spawn_tmask, {NT{1'b1}});
          nsp++;
        end
      end
      spawn_ready = 1'b0;
      chk("tbl_count", nsp, vecs[v].exp_cnt);
      chk("tbl_err", cta_err, vecs[v].exp_err);
      if (nsp > 0) begin
        chk("tbl_latency", first, 3);
        chk("tbl_busy_alloc", busy, 1);
      end
      for (int w = 0; w < nsp; w++) complete(w);
      step();
      chk("tbl_idle", busy, 0);
    end

    // two CTAs of 3: second waits for slots
    do_reset();
    push(32'd3, 32'd20);
    push(32'd3, 32'd21);
    collect(10, cnt, seq);
    chk("two_first_cnt", cnt, 3);
    chk("two_first_seq", seq, 32'h210);
    chk("two_wait_busy", busy, 1);
    complete(1);
    collect(4, cnt, seq);
    chk("two_wait_one_free", cnt, 0);
    complete(2);
    complete(0);
    spawn_ready = 1'b1;
    wmask = '0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (spawn_valid) begin
        chk("two_second_id", spawn_cta_id, 21);
        wmask[spawn_wid] = 1'b1;
        cnt++;
      end
      step();
    end
    spawn_ready = 1'b0;
    chk("two_second_cnt", cnt, 3);
    chk("two_second_set", wmask, 4'b0111);

    // zero-warp CTA then a normal one
    do_reset();
    push(32'd0, 32'd30);
    push(32'd2, 32'd31);
    collect(12, cnt, seq);
    chk("zero_cnt", cnt, 2);
    chk("zero_seq", seq, 32'h10);
    chk("zero_err", cta_err, 0);

    // oversize CTA then a normal one; error is sticky
    do_reset();
    push(32'd5, 32'd40);
    push(32'd1, 32'd41);
    collect(12, cnt, seq);
    chk("big_cnt", cnt, 1);
    chk("big_err", cta_err, 1);
    complete(0);
    step();
    chk("big_err_sticky", cta_err, 1);

    // backpressure: payload stable while spawn_ready low
    do_reset();
    push(32'd2, 32'd50);
    for (int c = 0; c < 10 && !spawn_valid; c++) step();
    chk("bp_valid", spawn_valid, 1);
    pw = spawn_wid; ppc = spawn_pc; plw = spawn_lwid;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("bp_hold_valid", spawn_valid, 1);
      chk("bp_hold", {spawn_wid, spawn_pc, spawn_lwid[7:0]}, {pw, ppc, plw[7:0]});
    end
    spawn_ready = 1'b1;
    step();
    chk("bp_next", {spawn_valid, spawn_wid, spawn_lwid[7:0]}, {1'b1, 2'd1, 8'd1});
    step();
    spawn_ready = 1'b0;
    chk("bp_end", spawn_valid, 0);

    // queue full: all slots held, one CTA stuck in CHECK, QUEUE_DEPTH more queued
    do_reset();
    push(32'd4, 32'd60);
    collect(10, cnt, seq);
    chk("full_alloc_cnt", cnt, 4);
    push(32'd1, 32'd61);
    push(32'd1, 32'd62);
    push(32'd1, 32'd63);
    step(); step();
    chk("full_ready", req_ready, 0);
    drive_req(32'd1, 32'd64);
    req_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("full_hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    for (int w = 0; w < 4; w++) complete(w);
    collect(30, cnt, seq);
    chk("full_drain_cnt", cnt, 3);

    // reset in the middle of a spawn burst
    do_reset();
    push(32'd3, 32'd70);
    for (int c = 0; c < 10 && !spawn_valid; c++) step();
    spawn_ready = 1'b1;
    step();
    spawn_ready = 1'b0;
    chk("mid_lwid", spawn_lwid, 1);
    reset = 1'b0;
    step();
    chk("mid_rst_valid", spawn_valid, 0);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b1;
    step();
    chk("mid_rst_ready", req_ready, 1);
    push(32'd4, 32'd71);
    collect(10, cnt, seq);
    chk("mid_all_free", seq, 32'h3210);

    // randomized traffic against an ordered-CTA / slot-ownership model
    do_reset();
    exp_q.delete();
    alloc = '0; cur = 0; exp_err = 0; pend = 0; tagc = 32'd100;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      feeding = (cyc < 3000);
      if (!feeding && exp_q.size() == 0 && alloc == '0) break;
      if (pend) begin
        chk("rnd_hold_valid", spawn_valid, 1);
        chk("rnd_hold", {spawn_wid, spawn_pc, spawn_lwid}, {pw, ppc, plw});
      end
      spawn_ready = ($urandom_range(0, 3) != 0);
      fired = 0;
      if (spawn_valid && spawn_ready) begin
        if (exp_q.size() == 0) chk("rnd_spurious_spawn", 1, 0);
        else begin
          chk("rnd_pc", spawn_pc, 32'h8000_0000 | exp_q[0].tag);
          chk("rnd_id", spawn_cta_id, exp_q[0].tag);
          chk("rnd_lwid", spawn_lwid, cur);
          chk("rnd_slot_free", alloc[spawn_wid], 0);
          alloc[spawn_wid] = 1'b1;
          fw = int'(spawn_wid);
          fired = 1;
          cur++;
          if (cur == int'(exp_q[0].n)) begin
            void'(exp_q.pop_front());
            cur = 0;
          end
        end
      end
      pend = spawn_valid && !spawn_ready;
      pw = spawn_wid; ppc = spawn_pc; plw = spawn_lwid;
      done_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, NW-1);
        found = 0;
        for (int j = 0; j < NW; j++) begin
          idx = (k + j) % NW;
          if (!found && alloc[idx] && !(fired && fw == idx)) begin
            found = 1;
            alloc[idx] = 1'b0;
            done_valid = 1'b1;
            done_wid = 2'(idx);
          end
        end
      end
      req_valid = 1'b0;
      if (feeding && req_ready && $urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, 9);
        if (r == 0)      nwv = 32'd0;
        else if (r < 8)  nwv = 32'($urandom_range(1, NW));
        else if (r == 8) nwv = 32'(NW + 1);
        else             nwv = 32'h8000_0001;
        drive_req(nwv, tagc);
        req_valid = 1'b1;
        if (nwv >= 1 && nwv <= NW) exp_q.push_back('{nwv, tagc});
        else if (nwv > NW) exp_err = 1;
        tagc++;
      end
      step();
    end
    done_valid = 1'b0;
    req_valid = 1'b0;
    spawn_ready = 1'b0;
    repeat (5) step();
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_alloc_empty", alloc, 0);
    chk("rnd_busy", busy, 0);
    chk("rnd_err", cta_err, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
